// File: rtl/cache_ram_port.sv
// cache_ram_port: RAM-side req/ack port for cache fill and write-back words.
// Returns fill data and pulses step_ready_out once per completed word.
module cache_ram_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_en_in,
    input  logic              ram_write_in,
    input  logic [1:0]        ram_addr_sel_in,
    input  logic [2:0]        word_idx_in,
    input  logic [ADDR_W-1:0] ram_addr_ic_in,
    input  logic [ADDR_W-1:0] ram_addr_dc_in,
    input  logic [ADDR_W-1:0] ram_addr_wb_in,
    input  logic [31:0]       wb_data_in,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [31:0]       mem_wdata_out,
    input  logic              mem_ack_in,
    input  logic [31:0]       mem_rdata_in,
    output logic [31:0]       fill_data_out,
    output logic              step_ready_out,
    output logic              busy_out,
    output logic              err_out
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_fill;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              r_abort;
    logic [ADDR_W-1:0] w_base;
    logic              w_start;
    logic              w_rsv;
    logic              w_tmo;
    assign w_base  = ram_addr_sel_in == 2'b00 ? ram_addr_ic_in :
                     ram_addr_sel_in == 2'b01 ? ram_addr_dc_in : ram_addr_wb_in;
    assign w_start = r_state == IDLE && ram_en_in && ram_addr_sel_in != 2'b10;
    assign w_rsv   = r_state == IDLE && ram_en_in && ram_addr_sel_in == 2'b10;
    assign w_tmo   = r_state == REQ && !mem_ack_in && r_cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? REQ : IDLE;
            REQ:     w_next = mem_ack_in ? DONE : w_tmo ? IDLE : REQ;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        mem_req_out    = r_state == REQ;
        mem_we_out     = r_state == REQ && r_we;
        step_ready_out = r_state == DONE && !r_abort;
        busy_out       = r_state != IDLE;
        mem_addr_out   = r_addr;
        mem_wdata_out  = r_wdata;
        fill_data_out  = r_fill;
        err_out        = r_err;
    end
    // A drop of ram_en_in at any point in REQ (including the ack cycle) aborts the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= (w_base & ~ADDR_W'(31)) | ADDR_W'({word_idx_in, 2'b00});
                r_we    <= ram_write_in;
                r_wdata <= wb_data_in;
                r_cnt   <= '0;
                r_abort <= 1'b0;
            end
            if (r_state == REQ) begin
                r_cnt   <= r_cnt + 8'd1;
                r_abort <= r_abort | ~ram_en_in;
            end
            if (r_state == REQ && mem_ack_in && !r_we && ram_en_in && !r_abort)
                r_fill <= mem_rdata_in;
            if (w_rsv || w_tmo)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_ram_port.sv
// tb_cache_ram_port: directed stimulus with a queue scoreboard for cache_ram_port.
// Stimulus pushes expected requests and fill words; a negedge monitor pops and compares.
module tb_cache_ram_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_en_in = 1'b0;
    logic        ram_write_in = 1'b0;
    logic [1:0]  ram_addr_sel_in = 2'b00;
    logic [2:0]  word_idx_in = 3'd0;
    logic [31:0] ram_addr_ic_in = '0;
    logic [31:0] ram_addr_dc_in = '0;
    logic [31:0] ram_addr_wb_in = '0;
    logic [31:0] wb_data_in = '0;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic [31:0] fill_data_out;
    logic        step_ready_out;
    logic        busy_out;
    logic        err_out;

    cache_ram_port #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ram_en_in(ram_en_in), .ram_write_in(ram_write_in),
        .ram_addr_sel_in(ram_addr_sel_in), .word_idx_in(word_idx_in),
        .ram_addr_ic_in(ram_addr_ic_in), .ram_addr_dc_in(ram_addr_dc_in),
        .ram_addr_wb_in(ram_addr_wb_in), .wb_data_in(wb_data_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in),
        .fill_data_out(fill_data_out), .step_ready_out(step_ready_out),
        .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] step_q[$];
    req_t        m_e;
    logic [31:0] fill_model = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_steps = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_out && mem_ack_in) begin
                if (req_q.size() == 0) check("unexpected_ack_handshake", 1, 0);
                else begin
                    m_e = req_q.pop_front();
                    check("mem_addr", mem_addr_out, m_e.addr);
                    check("mem_we", mem_we_out, m_e.we);
                    if (m_e.we) check("mem_wdata", mem_wdata_out, m_e.wdata);
                end
            end
            if (step_ready_out) begin
                n_steps++;
                if (step_q.size() == 0) check("unexpected_step_ready", 1, 0);
                else check("fill_data", fill_data_out, step_q.pop_front());
            end
        end
    end

    task automatic word(input logic [1:0] sel, input logic [2:0] idx, input logic wr,
                        input logic [31:0] wd, input int lat, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input bit abort, output int waits);
        req_t r;
        r.addr = exp_addr; r.we = wr; r.wdata = wd;
        req_q.push_back(r);
        if (!wr && !abort) fill_model = rd;
        if (!abort) step_q.push_back(fill_model);
        ram_en_in = 1'b1; ram_addr_sel_in = sel; word_idx_in = idx;
        ram_write_in = wr; wb_data_in = wd;
        waits = 0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (!mem_req_out && waits < 10);
        if (!mem_req_out) begin
            check("req_wait_expired", 0, 1);
            ram_en_in = 1'b0;
            return;
        end
        wb_data_in = 32'hFFFF_FFFF;
        if (abort) ram_en_in = 1'b0;
        repeat (lat) begin @(posedge clk); #1; end
        mem_ack_in = 1'b1; mem_rdata_in = rd;
        @(posedge clk); #1;
        mem_ack_in = 1'b0; ram_en_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cyc;
        bit saw;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_req", mem_req_out, 0);
        check("reset_busy", busy_out, 0);
        check("reset_err", err_out, 0);
        check("reset_fill", fill_data_out, 0);
        check("reset_step", step_ready_out, 0);
        ram_addr_ic_in = 32'h0000_0040; word_idx_in = 3'd1; ram_en_in = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_req", mem_req_out, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_req", mem_req_out, 0);
        check("async_reset_busy", busy_out, 0);
        check("async_reset_addr", mem_addr_out, 0);
        ram_en_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack_in = 1'b1;
        @(posedge clk); #1;
        mem_ack_in = 1'b0;
        check("stray_ack_step", step_ready_out, 0);
        check("stray_ack_busy", busy_out, 0);
        @(posedge clk); #1;
        check("stray_ack_step2", step_ready_out, 0);

        ram_addr_ic_in = 32'h0000_1234;
        word(2'b00, 3'd3, 1'b0, 32'h0, 2, 32'hDEAD_BEEF, 32'h0000_122C, 0, w);
        @(posedge clk); #1;
        check("fill_steps", n_steps, 1);
        check("fill_value", fill_data_out, 32'hDEAD_BEEF);

        ram_addr_wb_in = 32'h8000_0040;
        word(2'b11, 3'd7, 1'b1, 32'hA5A5_0001, 1, 32'h1234_5678, 32'h8000_005C, 0, w);
        @(posedge clk); #1;
        check("wb_steps", n_steps, 2);
        check("wb_fill_unchanged", fill_data_out, 32'hDEAD_BEEF);

        ram_addr_dc_in = 32'h0000_2010;
        for (int i = 0; i < 8; i++) begin
            word(2'b01, 3'(i), 1'b0, 32'h0, i % 4, 32'h1000_0000 + i, 32'h0000_2000 + 4 * i, 0, w);
            if (i > 0) check("burst_bubble", w, 2);
        end
        @(posedge clk); #1;
        check("burst_steps", n_steps, 10);
        check("burst_last_fill", fill_data_out, 32'h1000_0007);

        word(2'b00, 3'd0, 1'b0, 32'h0, 1, 32'hBAD0_BAD0, 32'h0000_1220, 1, w);
        repeat (2) @(posedge clk); #1;
        check("abort_steps", n_steps, 10);
        check("abort_fill", fill_data_out, 32'h1000_0007);
        check("abort_err", err_out, 0);

        ram_addr_sel_in = 2'b00; word_idx_in = 3'd2; ram_write_in = 1'b0; ram_en_in = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!mem_req_out && cyc < 10);
        cyc = 0;
        while (mem_req_out && cyc < 20) begin
            cyc++;
            @(posedge clk); #1;
        end
        ram_en_in = 1'b0;
        check("timeout_req_cycles", cyc, 4);
        check("timeout_err", err_out, 1);
        check("timeout_busy", busy_out, 0);
        repeat (3) @(posedge clk); #1;
        check("timeout_err_sticky", err_out, 1);
        check("timeout_steps", n_steps, 10);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("err_cleared", err_out, 0);
        ram_addr_sel_in = 2'b10; ram_en_in = 1'b1;
        saw = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_req_out) saw = 1;
        end
        ram_en_in = 1'b0;
        check("reserved_no_req", saw, 0);
        check("reserved_err", err_out, 1);
        check("reserved_busy", busy_out, 0);

        repeat (2) @(posedge clk); #1;
        check("req_queue_drained", req_q.size(), 0);
        check("step_queue_drained", step_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
